// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types, arctangent table and angle constants for the iterative CORDIC
package cordic_pkg;
  typedef enum logic {ROTATION = 1'b0, VECTORING = 1'b1} mode_e;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;
  localparam logic [31:0] ATAN_TABLE [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };
  function automatic logic [31:0] pi_half(input int w);
    return 32'(1) << (w - 2);
  endfunction
  function automatic logic [31:0] pi(input int w);
    return 32'(1) << (w - 1);
  endfunction
  function automatic logic [31:0] atan_scaled(input logic [4:0] i, input int w);
    logic [32:0] r;
    r = {1'b0, ATAN_TABLE[i]} + ((w < 32) ? (33'(1) << (31 - w)) : 33'(0));
    return 32'(r >> (32 - w));
  endfunction
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one combinational CORDIC micro-rotation, direction chosen by mode
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH+1:0] x,
  input  logic signed [WIDTH+1:0] y,
  input  logic        [WIDTH-1:0] z,
  input  logic        [4:0]       i,
  input  mode_e                   mode,
  output logic signed [WIDTH+1:0] x_n,
  output logic signed [WIDTH+1:0] y_n,
  output logic        [WIDTH-1:0] z_n
);
  logic                   d;
  logic signed [WIDTH+1:0] xs, ys;
  logic        [WIDTH-1:0] a;
  assign d   = (mode == VECTORING) ? y[WIDTH+1] : ~z[WIDTH-1];
  assign xs  = x >>> i;
  assign ys  = y >>> i;
  assign a   = WIDTH'(atan_scaled(i, WIDTH));
  assign x_n = d ? x - ys : x + ys;
  assign y_n = d ? y + xs : y - xs;
  assign z_n = d ? z - a : z + a;
endmodule

// File: rtl/cordic_iter.sv
// cordic_iter: iterative CORDIC, one micro-rotation per clock, with quadrant pre-rotation at load
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN_request_put,
  input  logic [3*WIDTH:0]   request_put,
  output logic               RDY_request_put,
  input  logic               EN_response_get,
  output logic [3*WIDTH+3:0] response_get,
  output logic               RDY_response_get
);
  localparam int XW = WIDTH + 2;
  localparam logic [WIDTH-1:0] PH = WIDTH'(pi_half(WIDTH));
  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);
  state_e               state_q, state_d;
  mode_e                mode_q, mode_d, mode_in;
  logic [4:0]           cnt_q, cnt_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_in, y_in, x_pre, y_pre, x_nx, y_nx;
  logic [WIDTH-1:0]     z_q, z_d, z_in, z_pre, z_nx;
  logic                 rot_p, rot_m;
  assign mode_in = mode_e'(request_put[3*WIDTH]);
  assign x_in    = XW'($signed(request_put[3*WIDTH-1 -: WIDTH]));
  assign y_in    = XW'($signed(request_put[2*WIDTH-1 -: WIDTH]));
  assign z_in    = request_put[WIDTH-1:0];
  // rot_p turns by -pi/2 giving (y,-x,z+pi/2); rot_m turns by +pi/2 giving (-y,x,z-pi/2)
  assign rot_p = (mode_in == VECTORING) ? (x_in[XW-1] & ~y_in[XW-1]) : (z_in[WIDTH-1 -: 2] == 2'b10);
  assign rot_m = (mode_in == VECTORING) ? (x_in[XW-1] & y_in[XW-1]) : (z_in[WIDTH-1 -: 2] == 2'b01);
  assign x_pre = rot_p ? y_in : rot_m ? -y_in : x_in;
  assign y_pre = rot_p ? -x_in : rot_m ? x_in : y_in;
  assign z_pre = rot_p ? z_in + PH : rot_m ? z_in - PH : z_in;
  cordic_stage #(.WIDTH(WIDTH)) u_stage (
    .x(x_q), .y(y_q), .z(z_q), .i(cnt_q), .mode(mode_q),
    .x_n(x_nx), .y_n(y_nx), .z_n(z_nx)
  );
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      IDLE: if (EN_request_put) begin
        state_d = ITER;
        mode_d  = mode_in;
        cnt_d   = '0;
        x_d     = x_pre;
        y_d     = y_pre;
        z_d     = z_pre;
      end
      ITER: begin
        x_d     = x_nx;
        y_d     = y_nx;
        z_d     = z_nx;
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == LAST) ? DONE : ITER;
      end
      DONE:    state_d = EN_response_get ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      mode_q  <= ROTATION;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end
  assign RDY_request_put  = state_q == IDLE;
  assign RDY_response_get = state_q == DONE;
  assign response_get     = {x_q, y_q, z_q};
endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: directed table, handshake corner cases and a bit-exact random sweep for cordic_iter
module tb_cordic_iter;
  localparam int TOL = 8;
  localparam int ATAN [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN_request_put = 1'b0;
  logic [48:0] request_put = '0;
  logic        RDY_request_put;
  logic        EN_response_get = 1'b0;
  logic [51:0] response_get;
  logic        RDY_response_get;
  int          errors = 0;
  int          checks = 0;
  cordic_iter #(.WIDTH(16), .ITERATIONS(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .EN_request_put(EN_request_put), .request_put(request_put), .RDY_request_put(RDY_request_put),
    .EN_response_get(EN_response_get), .response_get(response_get), .RDY_response_get(RDY_response_get)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic m;
    int   x, y, z, ex, ey, ez;
  } vec_t;
  task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask
  function automatic int sx(input logic [17:0] a);
    return int'($signed(a));
  endfunction
  function automatic int zd(input logic [15:0] a, input int b);
    logic [15:0] t;
    t = a - 16'(b);
    return int'($signed(t));
  endfunction
  // bit-exact reference: floor-shift micro-rotations on 18-bit x/y, 16-bit wrapped z
  function automatic logic [51:0] model(input logic m, input int xi, input int yi, input int zi);
    int x, y, z, t;
    logic d;
    x = xi;
    y = yi;
    z = zi & 'hFFFF;
    if (m) begin
      if (x < 0 && y >= 0) begin t = x; x = y; y = -t; z = z + 16384; end
      else if (x < 0) begin t = x; x = -y; y = t; z = z - 16384; end
    end else begin
      if (((z >> 14) & 3) == 1) begin t = x; x = -y; y = t; z = z - 16384; end
      else if (((z >> 14) & 3) == 2) begin t = x; x = y; y = -t; z = z + 16384; end
    end
    z = z & 'hFFFF;
    for (int i = 0; i < 16; i++) begin
      d = m ? (y < 0) : (z < 32768);
      t = x;
      x = d ? x - (y >>> i) : x + (y >>> i);
      y = d ? y + (t >>> i) : y - (t >>> i);
      z = (d ? z - ATAN[i] : z + ATAN[i]) & 'hFFFF;
    end
    return {18'(x), 18'(y), 16'(z)};
  endfunction
  task automatic put(input logic m, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    int n;
    n = 0;
    while (!RDY_request_put && n < 100) begin @(negedge CLK); n++; end
    if (n >= 100) chk("idle_timeout", n, 0, 0);
    request_put    = {m, x, y, z};
    EN_request_put = 1'b1;
    @(negedge CLK);
    EN_request_put = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!RDY_response_get && lat < 100) begin @(negedge CLK); lat++; end
  endtask
  task automatic get();
    EN_response_get = 1'b1;
    @(negedge CLK);
    EN_response_get = 1'b0;
  endtask
  task automatic run(input logic m, input int x, input int y, input int z, output logic [51:0] r, output int lat);
    put(m, 16'(x), 16'(y), 16'(z));
    wait_done(lat);
    r = response_get;
    get();
  endtask
  initial begin
    vec_t        v[8];
    logic [51:0] r, r0;
    int          lat;
    logic        m;
    logic signed [15:0] xr, yr;
    logic [15:0] zr;
    v[0] = '{1'b1,  16384,     0, 'h0000,  26981,      0, 'h0000};
    v[1] = '{1'b1,      0, 16384, 'h0000,  26981,      0, 'h4000};
    v[2] = '{1'b1, -16384,     0, 'h0000,  26981,      0, 'h8000};
    v[3] = '{1'b1,  16384, 16384, 'h0000,  38158,      0, 'h2000};
    v[4] = '{1'b0,  16384,     0, 'h2000,  19079,  19079, 'h0000};
    v[5] = '{1'b0,  16384,     0, 'hA000, -19079, -19079, 'h0000};
    v[6] = '{1'b0,  16384,     0, 'h4000,      0,  26981, 'h0000};
    v[7] = '{1'b0,      0, 16384, 'hC000,  26981,      0, 'h0000};
    #12;
    chk("reset_rdy_put", RDY_request_put, 1, 0);
    chk("reset_rdy_get", RDY_response_get, 0, 0);
    chk("reset_resp", response_get, 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 8; k++) begin
      run(v[k].m, v[k].x, v[k].y, v[k].z, r, lat);
      chk($sformatf("v%0d_latency", k), lat, 16, 0);
      chk($sformatf("v%0d_x", k), sx(r[51:34]), v[k].ex, TOL);
      chk($sformatf("v%0d_y", k), sx(r[33:16]), v[k].ey, TOL);
      chk($sformatf("v%0d_zdiff", k), zd(r[15:0], v[k].ez), 0, TOL);
      chk($sformatf("v%0d_exact", k), r, model(v[k].m, v[k].x, v[k].y, v[k].z), 0);
      chk($sformatf("v%0d_idle_after_get", k), RDY_request_put, 1, 0);
    end
    // hand-traced floor-shift result for vectoring (16384,0,0)
    run(1'b1, 16384, 0, 0, r, lat);
    chk("trace_x", sx(r[51:34]), 26985, 0);
    chk("trace_y", sx(r[33:16]), -1, 0);
    chk("trace_z", r[15:0], 0, 0);
    put(1'b0, 16'd16384, 16'd0, 16'h2000);
    wait_done(lat);
    chk("bp_latency", lat, 16, 0);
    r0 = response_get;
    for (int i = 0; i < 50; i++) begin
      request_put    = {1'b1, 16'(i * 321), 16'(i * 77), 16'(i)};
      EN_request_put = i[0];
      @(negedge CLK);
      chk("bp_stable", response_get, r0, 0);
      chk("bp_rdy_put", RDY_request_put, 0, 0);
      chk("bp_rdy_get", RDY_response_get, 1, 0);
    end
    EN_request_put = 1'b0;
    get();
    chk("bp_release_rdy_put", RDY_request_put, 1, 0);
    chk("bp_release_rdy_get", RDY_response_get, 0, 0);
    chk("bp_exact", r0, model(1'b0, 16384, 0, 'h2000), 0);
    put(1'b1, 16'd16384, 16'd0, 16'd0);
    repeat (7) @(negedge CLK);
    chk("mid_busy", RDY_request_put, 0, 0);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_rdy_get", RDY_response_get, 0, 0);
    chk("abort_resp", response_get, 0, 0);
    chk("abort_rdy_put", RDY_request_put, 1, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    run(1'b1, 16384, 0, 0, r, lat);
    chk("post_reset_latency", lat, 16, 0);
    chk("post_reset_exact", r, model(1'b1, 16384, 0, 0), 0);
    for (int k = 0; k < 1000; k++) begin
      m  = 1'($urandom);
      xr = 16'($urandom);
      yr = 16'($urandom);
      zr = 16'($urandom);
      run(m, int'(xr), int'(yr), int'(zr), r, lat);
      chk("rnd_latency", lat, 16, 0);
      chk($sformatf("rnd%0d_exact", k), r, model(m, int'(xr), int'(yr), int'(zr)), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
